// File: rtl/ysyx_pkg.sv
// Shared decode definitions for the ysyx decode stage.
// Holds the ALU opcode set, RV32 major opcodes, the encodings of the
// branch / writeback / data-memory select fields, the registered decode
// bundle type and immediate extraction helpers.
package ysyx_pkg;

   // ALU operation codes
   localparam logic [4:0] AluAdd    = 5'd0;
   localparam logic [4:0] AluSub    = 5'd1;
   localparam logic [4:0] AluSll    = 5'd2;
   localparam logic [4:0] AluSlt    = 5'd3;
   localparam logic [4:0] AluSltu   = 5'd4;
   localparam logic [4:0] AluXor    = 5'd5;
   localparam logic [4:0] AluSrl    = 5'd6;
   localparam logic [4:0] AluSra    = 5'd7;
   localparam logic [4:0] AluOr     = 5'd8;
   localparam logic [4:0] AluAnd    = 5'd9;
   localparam logic [4:0] AluLui    = 5'd10;  // pass operand b
   localparam logic [4:0] AluMul    = 5'd11;
   localparam logic [4:0] AluMulh   = 5'd12;
   localparam logic [4:0] AluMulhsu = 5'd13;
   localparam logic [4:0] AluMulhu  = 5'd14;
   localparam logic [4:0] AluDiv    = 5'd15;
   localparam logic [4:0] AluDivu   = 5'd16;
   localparam logic [4:0] AluRem    = 5'd17;
   localparam logic [4:0] AluRemu   = 5'd18;

   // RV32 major opcodes
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcFence  = 7'b0001111;
   localparam logic [6:0] OpcSystem = 7'b1110011;

   // Branch type
   localparam logic [2:0] BrNone = 3'b000;
   localparam logic [2:0] BrEq   = 3'b010;
   localparam logic [2:0] BrNe   = 3'b011;
   localparam logic [2:0] BrLt   = 3'b100;
   localparam logic [2:0] BrGe   = 3'b101;
   localparam logic [2:0] BrLtu  = 3'b110;
   localparam logic [2:0] BrGeu  = 3'b111;

   // Register-file writeback source
   localparam logic [1:0] WrNone = 2'b00;
   localparam logic [1:0] WrPc4  = 2'b01;
   localparam logic [1:0] WrAlu  = 2'b10;
   localparam logic [1:0] WrMem  = 2'b11;

   // Data-memory read / write kinds
   localparam logic [2:0] DmRdNone = 3'b000;
   localparam logic [2:0] DmRdLb   = 3'b001;
   localparam logic [2:0] DmRdLbu  = 3'b010;
   localparam logic [2:0] DmRdLh   = 3'b011;
   localparam logic [2:0] DmRdLhu  = 3'b100;
   localparam logic [2:0] DmRdLw   = 3'b101;

   localparam logic [1:0] DmWrNone = 2'b00;
   localparam logic [1:0] DmWrSb   = 2'b01;
   localparam logic [1:0] DmWrSh   = 2'b10;
   localparam logic [1:0] DmWrSw   = 2'b11;

   // System event kinds
   localparam logic [1:0] SysNone   = 2'b00;
   localparam logic [1:0] SysEbreak = 2'b01;
   localparam logic [1:0] SysEcall  = 2'b10;

   typedef struct packed {
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rf_wr_en;
      logic [1:0]  rf_wr_sel;
      logic        do_jump;
      logic [2:0]  br_type;
      logic        alu_a_sel;
      logic        alu_b_sel;
      logic [4:0]  alu_ctrl;
      logic [2:0]  dm_rd_sel;
      logic [1:0]  dm_wr_sel;
      logic        illegal;
      logic [1:0]  sys_kind;
   } decode_t;

   function automatic logic [31:0] imm_i(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:25], inst[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] inst);
      return {inst[31:12], 12'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/ysyx_idu_fifo.sv
// Synchronous FIFO buffering fetched {pc, inst} pairs.
// Ports: clk_i/rst_i (sync active-high), flush_i empties it at the next edge;
// wr_valid_i/wr_ready_o/wr_data_i push side; rd_en_i requests a pop,
// rd_valid_o (non-empty) / rd_data_o expose the head; count_o is occupancy.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ysyx_idu_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic             rd_valid_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [AW:0]      count_o
);

   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             full, empty, push, pop;

   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);

   // Flush takes priority: a push or pop in the flush cycle is discarded.
   assign push = wr_valid_i & ~full & ~flush_i;
   assign pop  = rd_en_i & ~empty & ~flush_i;

   always_comb begin
      wptr_d = wptr_q + {{AW{1'b0}}, push};
      rptr_d = rptr_q + {{AW{1'b0}}, pop};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   assign wr_ready_o = ~full;
   assign rd_valid_o = ~empty;
   assign rd_data_o  = mem_q[rptr_q[AW-1:0]];
   assign count_o    = wptr_q - rptr_q;

endmodule

// File: rtl/ysyx_idu_pipe.sv
// Pipelined RV32I(+M) decode stage between IFU and EXU.
// Ports: clk/rst (sync active-high), flush; in_valid/in_ready/in_pc/in_inst
// from the IFU; out_valid/out_ready plus the registered decode bundle
// (out_pc, out_imm, register indices, writeback/branch/ALU/memory selects,
// illegal) to the EXU; sys_evt pulses one cycle after an ebreak/ecall is
// handed over; count is FIFO occupancy.
module ysyx_idu_pipe
   import ysyx_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter bit          HAS_M = 1'b1,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_imm,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic             rf_wr_en,
   output logic [1:0]       rf_wr_sel,
   output logic             do_jump,
   output logic [2:0]       BrType,
   output logic             alu_a_sel,
   output logic             alu_b_sel,
   output logic [4:0]       alu_ctrl,
   output logic [2:0]       dm_rd_sel,
   output logic [1:0]       dm_wr_sel,
   output logic             illegal,
   output logic [1:0]       sys_evt,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   function automatic decode_t decode(input logic [31:0] inst);
      decode_t    d;
      decode_t    z;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = inst[14:12];
      f7 = inst[31:25];
      d = '0;
      d.rs1 = inst[19:15];
      d.rs2 = inst[24:20];
      d.rd  = inst[11:7];
      case (inst[6:0])
         OpcLui: begin
            d.imm = imm_u(inst); d.rf_wr_en = 1'b1; d.rf_wr_sel = WrAlu;
            d.alu_b_sel = 1'b1; d.alu_ctrl = AluLui;
         end
         OpcAuipc: begin
            d.imm = imm_u(inst); d.rf_wr_en = 1'b1; d.rf_wr_sel = WrAlu;
            d.alu_b_sel = 1'b1; d.alu_ctrl = AluAdd;
         end
         OpcJal: begin
            d.imm = imm_j(inst); d.rf_wr_en = 1'b1; d.rf_wr_sel = WrPc4;
            d.do_jump = 1'b1; d.alu_b_sel = 1'b1; d.alu_ctrl = AluAdd;
         end
         OpcJalr: begin
            d.imm = imm_i(inst); d.rf_wr_en = 1'b1; d.rf_wr_sel = WrPc4;
            d.do_jump = 1'b1; d.alu_a_sel = 1'b1; d.alu_b_sel = 1'b1; d.alu_ctrl = AluAdd;
            d.illegal = (f3 != 3'b000);
         end
         OpcBranch: begin
            // ALU forms pc+imm; the comparison itself is selected by BrType
            d.imm = imm_b(inst); d.alu_b_sel = 1'b1; d.alu_ctrl = AluAdd;
            case (f3)
               3'b000:  d.br_type = BrEq;
               3'b001:  d.br_type = BrNe;
               3'b100:  d.br_type = BrLt;
               3'b101:  d.br_type = BrGe;
               3'b110:  d.br_type = BrLtu;
               3'b111:  d.br_type = BrGeu;
               default: d.illegal = 1'b1;
            endcase
         end
         OpcLoad: begin
            d.imm = imm_i(inst); d.rf_wr_en = 1'b1; d.rf_wr_sel = WrMem;
            d.alu_a_sel = 1'b1; d.alu_b_sel = 1'b1; d.alu_ctrl = AluAdd;
            case (f3)
               3'b000:  d.dm_rd_sel = DmRdLb;
               3'b100:  d.dm_rd_sel = DmRdLbu;
               3'b001:  d.dm_rd_sel = DmRdLh;
               3'b101:  d.dm_rd_sel = DmRdLhu;
               3'b010:  d.dm_rd_sel = DmRdLw;
               default: d.illegal = 1'b1;
            endcase
         end
         OpcStore: begin
            d.imm = imm_s(inst); d.alu_a_sel = 1'b1; d.alu_b_sel = 1'b1; d.alu_ctrl = AluAdd;
            case (f3)
               3'b000:  d.dm_wr_sel = DmWrSb;
               3'b001:  d.dm_wr_sel = DmWrSh;
               3'b010:  d.dm_wr_sel = DmWrSw;
               default: d.illegal = 1'b1;
            endcase
         end
         OpcOpImm: begin
            d.imm = imm_i(inst); d.rf_wr_en = 1'b1; d.rf_wr_sel = WrAlu;
            d.alu_a_sel = 1'b1; d.alu_b_sel = 1'b1;
            case (f3)
               3'b000: d.alu_ctrl = AluAdd;
               3'b010: d.alu_ctrl = AluSlt;
               3'b011: d.alu_ctrl = AluSltu;
               3'b100: d.alu_ctrl = AluXor;
               3'b110: d.alu_ctrl = AluOr;
               3'b111: d.alu_ctrl = AluAnd;
               3'b001: begin
                  d.alu_ctrl = AluSll;
                  d.illegal  = (f7 != 7'b0000000);
               end
               default: begin
                  d.alu_ctrl = (f7[5]) ? AluSra : AluSrl;
                  d.illegal  = (f7 != 7'b0000000) && (f7 != 7'b0100000);
               end
            endcase
         end
         OpcOp: begin
            d.rf_wr_en = 1'b1; d.rf_wr_sel = WrAlu; d.alu_a_sel = 1'b1;
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  d.alu_ctrl = AluAdd;
                  3'b001:  d.alu_ctrl = AluSll;
                  3'b010:  d.alu_ctrl = AluSlt;
                  3'b011:  d.alu_ctrl = AluSltu;
                  3'b100:  d.alu_ctrl = AluXor;
                  3'b101:  d.alu_ctrl = AluSrl;
                  3'b110:  d.alu_ctrl = AluOr;
                  default: d.alu_ctrl = AluAnd;
               endcase
            end else if (f7 == 7'b0100000) begin
               case (f3)
                  3'b000:  d.alu_ctrl = AluSub;
                  3'b101:  d.alu_ctrl = AluSra;
                  default: d.illegal  = 1'b1;
               endcase
            end else if ((f7 == 7'b0000001) && HAS_M) begin
               case (f3)
                  3'b000:  d.alu_ctrl = AluMul;
                  3'b001:  d.alu_ctrl = AluMulh;
                  3'b010:  d.alu_ctrl = AluMulhsu;
                  3'b011:  d.alu_ctrl = AluMulhu;
                  3'b100:  d.alu_ctrl = AluDiv;
                  3'b101:  d.alu_ctrl = AluDivu;
                  3'b110:  d.alu_ctrl = AluRem;
                  default: d.alu_ctrl = AluRemu;
               endcase
            end else begin
               d.illegal = 1'b1;
            end
         end
         OpcFence: ;  // nop: legal with every control at zero
         OpcSystem: begin
            if (inst == 32'h0010_0073) begin
               d.sys_kind = SysEbreak;
            end else if (inst == 32'h0000_0073) begin
               d.sys_kind = SysEcall;
            end else begin
               d.illegal = 1'b1;
            end
         end
         default: d.illegal = 1'b1;
      endcase
      // Illegal words keep only their raw register fields; no side effects leak out.
      if (d.illegal) begin
         z = '0;
         z.illegal = 1'b1;
         z.rs1 = d.rs1;
         z.rs2 = d.rs2;
         z.rd  = d.rd;
         d = z;
      end
      if (d.rd == 5'd0) begin
         d.rf_wr_en = 1'b0;
      end
      return d;
   endfunction

   logic          fifo_rd_valid;
   logic [63:0]   fifo_rd_data;
   logic [AW:0]   fifo_count;
   logic          stage_free, load, out_fire;
   logic          valid_q, valid_d;
   logic [31:0]   pc_q;
   decode_t       bundle_q;
   logic [1:0]    sys_evt_q, sys_evt_d;

   // Output stage can take a new entry when empty or being consumed this cycle.
   assign stage_free = ~valid_q | out_ready;

   ysyx_idu_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .wr_valid_i (in_valid),
      .wr_ready_o (in_ready),
      .wr_data_i  ({in_pc, in_inst}),
      .rd_en_i    (stage_free),
      .rd_valid_o (fifo_rd_valid),
      .rd_data_o  (fifo_rd_data),
      .count_o    (fifo_count)
   );

   always_comb begin
      out_fire  = valid_q & out_ready;
      load      = fifo_rd_valid & stage_free & ~flush;
      valid_d   = valid_q;
      sys_evt_d = SysNone;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
      end else if (out_fire) begin
         valid_d = 1'b0;
      end
      // A bundle handed over in the flush cycle is discarded, so no event.
      if (out_fire && !flush) begin
         sys_evt_d = bundle_q.sys_kind;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         bundle_q  <= '0;
         sys_evt_q <= SysNone;
      end else begin
         valid_q   <= valid_d;
         sys_evt_q <= sys_evt_d;
         if (load) begin
            pc_q     <= fifo_rd_data[63:32];
            bundle_q <= decode(fifo_rd_data[31:0]);
         end
      end
   end

   assign out_valid = valid_q;
   assign out_pc    = pc_q;
   assign out_imm   = bundle_q.imm;
   assign out_rs1   = bundle_q.rs1;
   assign out_rs2   = bundle_q.rs2;
   assign out_rd    = bundle_q.rd;
   assign rf_wr_en  = bundle_q.rf_wr_en;
   assign rf_wr_sel = bundle_q.rf_wr_sel;
   assign do_jump   = bundle_q.do_jump;
   assign BrType    = bundle_q.br_type;
   assign alu_a_sel = bundle_q.alu_a_sel;
   assign alu_b_sel = bundle_q.alu_b_sel;
   assign alu_ctrl  = bundle_q.alu_ctrl;
   assign dm_rd_sel = bundle_q.dm_rd_sel;
   assign dm_wr_sel = bundle_q.dm_wr_sel;
   assign illegal   = bundle_q.illegal;
   assign sys_evt   = sys_evt_q;
   assign count     = CNT_W'(fifo_count);

endmodule

// File: tb/tb_ysyx_idu_pipe.sv
// Self-checking bench for ysyx_idu_pipe: a table of decode vectors pushed one
// at a time, then hand-written backpressure, ebreak/ecall and flush sequences.
// A second instance with HAS_M=0 shares the stimulus to check M-group rejection.
module tb_ysyx_idu_pipe;
   import ysyx_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_inst;

   logic             in_ready, out_valid, rf_wr_en, do_jump, alu_a_sel, alu_b_sel, illegal;
   logic [31:0]      out_pc, out_imm;
   logic [4:0]       out_rs1, out_rs2, out_rd, alu_ctrl;
   logic [1:0]       rf_wr_sel, dm_wr_sel, sys_evt;
   logic [2:0]       br_type, dm_rd_sel;
   logic [CNT_W-1:0] count;

   logic             nm_in_ready, nm_out_valid, nm_rf_wr_en, nm_do_jump, nm_alu_a_sel;
   logic             nm_alu_b_sel, nm_illegal;
   logic [31:0]      nm_out_pc, nm_out_imm;
   logic [4:0]       nm_out_rs1, nm_out_rs2, nm_out_rd, nm_alu_ctrl;
   logic [1:0]       nm_rf_wr_sel, nm_dm_wr_sel, nm_sys_evt;
   logic [2:0]       nm_br_type, nm_dm_rd_sel;
   logic [CNT_W-1:0] nm_count;

   always #5 clk = ~clk;

   ysyx_idu_pipe #(.DEPTH(DEPTH), .HAS_M(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rd(out_rd), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .do_jump(do_jump),
      .BrType(br_type), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl),
      .dm_rd_sel(dm_rd_sel), .dm_wr_sel(dm_wr_sel), .illegal(illegal), .sys_evt(sys_evt),
      .count(count)
   );

   ysyx_idu_pipe #(.DEPTH(DEPTH), .HAS_M(1'b0)) dut_nm (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(nm_out_valid), .out_ready(out_ready),
      .out_pc(nm_out_pc), .out_imm(nm_out_imm), .out_rs1(nm_out_rs1), .out_rs2(nm_out_rs2),
      .out_rd(nm_out_rd), .rf_wr_en(nm_rf_wr_en), .rf_wr_sel(nm_rf_wr_sel),
      .do_jump(nm_do_jump), .BrType(nm_br_type), .alu_a_sel(nm_alu_a_sel),
      .alu_b_sel(nm_alu_b_sel), .alu_ctrl(nm_alu_ctrl), .dm_rd_sel(nm_dm_rd_sel),
      .dm_wr_sel(nm_dm_wr_sel), .illegal(nm_illegal), .sys_evt(nm_sys_evt), .count(nm_count)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic        we;
      logic [1:0]  wsel;
      logic        jmp;
      logic [2:0]  br;
      logic        asel, bsel;
      logic [4:0]  alu;
      logic [2:0]  dmr;
      logic [1:0]  dmw;
      logic        ill;
      logic        ill_nm;
   } vec_t;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      else n_pass++;
   endtask

   // Starts and ends at a negedge; assumes in_ready is high.
   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      in_valid = 1'b1;
      in_pc    = pc;
      in_inst  = inst;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t vecs[13];
      int   n;
      // inst, imm, rs1, rs2, rd, we, wsel, jmp, br, asel, bsel, alu, dmr, dmw, ill, ill_nm
      vecs[0]  = '{32'h00500093, 32'd5,        5'd0, 5'd5,  5'd1,  1, 2'b10, 0, 3'b000, 1, 1, AluAdd, 3'b000, 2'b00, 0, 0};
      vecs[1]  = '{32'hFE209CE3, 32'hFFFFFFF8, 5'd1, 5'd2,  5'd25, 0, 2'b00, 0, 3'b011, 0, 1, AluAdd, 3'b000, 2'b00, 0, 0};
      vecs[2]  = '{32'h00225183, 32'd2,        5'd4, 5'd2,  5'd3,  1, 2'b11, 0, 3'b000, 1, 1, AluAdd, 3'b100, 2'b00, 0, 0};
      vecs[3]  = '{32'h027302B3, 32'd0,        5'd6, 5'd7,  5'd5,  1, 2'b10, 0, 3'b000, 1, 0, AluMul, 3'b000, 2'b00, 0, 1};
      vecs[4]  = '{32'h0020A423, 32'd8,        5'd1, 5'd2,  5'd8,  0, 2'b00, 0, 3'b000, 1, 1, AluAdd, 3'b000, 2'b11, 0, 0};
      vecs[5]  = '{32'h010000EF, 32'd16,       5'd0, 5'd16, 5'd1,  1, 2'b01, 1, 3'b000, 0, 1, AluAdd, 3'b000, 2'b00, 0, 0};
      vecs[6]  = '{32'h123452B7, 32'h12345000, 5'd8, 5'd3,  5'd5,  1, 2'b10, 0, 3'b000, 0, 1, AluLui, 3'b000, 2'b00, 0, 0};
      vecs[7]  = '{32'h402081B3, 32'd0,        5'd1, 5'd2,  5'd3,  1, 2'b10, 0, 3'b000, 1, 0, AluSub, 3'b000, 2'b00, 0, 0};
      vecs[8]  = '{32'h40325213, 32'h00000403, 5'd4, 5'd3,  5'd4,  1, 2'b10, 0, 3'b000, 1, 1, AluSra, 3'b000, 2'b00, 0, 0};
      vecs[9]  = '{32'hFFFFFFFF, 32'd0,        5'd31,5'd31, 5'd31, 0, 2'b00, 0, 3'b000, 0, 0, AluAdd, 3'b000, 2'b00, 1, 1};
      vecs[10] = '{32'h0FF0000F, 32'd0,        5'd0, 5'd31, 5'd0,  0, 2'b00, 0, 3'b000, 0, 0, AluAdd, 3'b000, 2'b00, 0, 0};
      vecs[11] = '{32'h00000013, 32'd0,        5'd0, 5'd0,  5'd0,  0, 2'b10, 0, 3'b000, 1, 1, AluAdd, 3'b000, 2'b00, 0, 0};
      vecs[12] = '{32'h00200073, 32'd0,        5'd0, 5'd2,  5'd0,  0, 2'b00, 0, 3'b000, 0, 0, AluAdd, 3'b000, 2'b00, 1, 1};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_pc = '0; in_inst = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.count",     32'(count),     32'd0);
      chk("rst.in_ready",  32'(in_ready),  32'd1);
      chk("rst.sys_evt",   32'(sys_evt),   32'd0);
      chk("rst.out_pc",    out_pc,         32'd0);
      chk("rst.imm",       out_imm,        32'd0);
      chk("rst.we",        32'(rf_wr_en),  32'd0);
      chk("rst.illegal",   32'(illegal),   32'd0);

      // Decode table, one instruction at a time with out_ready high
      for (int i = 0; i < 13; i++) begin
         logic [31:0] pc;
         pc = 32'h8000_0000 + 32'(4 * i);
         push(pc, vecs[i].inst);
         chk($sformatf("v%0d.valid_early", i), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d.count_in", i),    32'(count),     32'd1);
         @(negedge clk);
         chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d.count", i), 32'(count),     32'd0);
         chk($sformatf("v%0d.pc", i),    out_pc,         pc);
         chk($sformatf("v%0d.imm", i),   out_imm,        vecs[i].imm);
         chk($sformatf("v%0d.rs1", i),   32'(out_rs1),   32'(vecs[i].rs1));
         chk($sformatf("v%0d.rs2", i),   32'(out_rs2),   32'(vecs[i].rs2));
         chk($sformatf("v%0d.rd", i),    32'(out_rd),    32'(vecs[i].rd));
         chk($sformatf("v%0d.we", i),    32'(rf_wr_en),  32'(vecs[i].we));
         chk($sformatf("v%0d.wsel", i),  32'(rf_wr_sel), 32'(vecs[i].wsel));
         chk($sformatf("v%0d.jump", i),  32'(do_jump),   32'(vecs[i].jmp));
         chk($sformatf("v%0d.br", i),    32'(br_type),   32'(vecs[i].br));
         chk($sformatf("v%0d.asel", i),  32'(alu_a_sel), 32'(vecs[i].asel));
         chk($sformatf("v%0d.bsel", i),  32'(alu_b_sel), 32'(vecs[i].bsel));
         chk($sformatf("v%0d.alu", i),   32'(alu_ctrl),  32'(vecs[i].alu));
         chk($sformatf("v%0d.dmr", i),   32'(dm_rd_sel), 32'(vecs[i].dmr));
         chk($sformatf("v%0d.dmw", i),   32'(dm_wr_sel), 32'(vecs[i].dmw));
         chk($sformatf("v%0d.ill", i),   32'(illegal),   32'(vecs[i].ill));
         chk($sformatf("v%0d.sys", i),   32'(sys_evt),   32'd0);
         chk($sformatf("v%0d.nm_ill", i), 32'(nm_illegal), 32'(vecs[i].ill_nm));
         chk($sformatf("v%0d.nm_we", i),  32'(nm_rf_wr_en),
             vecs[i].ill_nm ? 32'd0 : 32'(vecs[i].we));
      end
      @(negedge clk);

      // Backpressure: fill FIFO plus output stage, then drain in order
      out_ready = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && in_ready; c++) begin
         in_valid = 1'b1;
         in_pc    = 32'h1000 + 32'(4 * n);
         in_inst  = {12'(n + 1), 5'd0, 3'b000, 5'd2, 7'h13};
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp.accepted",  32'(n),         32'(DEPTH + 1));
      chk("bp.count",     32'(count),     32'(DEPTH));
      chk("bp.in_ready",  32'(in_ready),  32'd0);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_pc",   out_pc,         32'h1000);
      out_ready = 1'b1;
      for (int k = 0; k < DEPTH + 1; k++) begin
         chk($sformatf("drain%0d.valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("drain%0d.pc", k),    out_pc,         32'h1000 + 32'(4 * k));
         chk($sformatf("drain%0d.imm", k),   out_imm,        32'(k + 1));
         @(posedge clk);
         @(negedge clk);
      end
      chk("drain.empty_valid", 32'(out_valid), 32'd0);
      chk("drain.count",       32'(count),     32'd0);

      // ebreak held by a 3-cycle stall, then a single sys_evt pulse
      out_ready = 1'b0;
      push(32'h2000, 32'h0010_0073);
      chk("eb.sys_push", 32'(sys_evt), 32'd0);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("eb.stall%0d.valid", s), 32'(out_valid), 32'd1);
         chk($sformatf("eb.stall%0d.sys", s),   32'(sys_evt),   32'd0);
         @(negedge clk);
      end
      chk("eb.illegal", 32'(illegal), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("eb.pulse",       32'(sys_evt),   32'd1);
      chk("eb.valid_after", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("eb.pulse_end",   32'(sys_evt),   32'd0);

      // ecall with no stall
      push(32'h2004, 32'h0000_0073);
      @(negedge clk);
      chk("ec.valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      chk("ec.pulse", 32'(sys_evt), 32'd2);
      @(negedge clk);
      chk("ec.pulse_end", 32'(sys_evt), 32'd0);

      // Flush with 3 buffered entries, an ebreak being handed over and a push
      out_ready = 1'b0;
      push(32'h2100, 32'h0010_0073);
      push(32'h2104, 32'h00100093);
      push(32'h2108, 32'h00200093);
      push(32'h210C, 32'h00300093);
      chk("fl.count_before", 32'(count),     32'd3);
      chk("fl.valid_before", 32'(out_valid), 32'd1);
      flush     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_pc     = 32'h2110;
      in_inst   = 32'h00400093;
      @(posedge clk);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl.count",     32'(count),     32'd0);
      chk("fl.out_valid", 32'(out_valid), 32'd0);
      chk("fl.in_ready",  32'(in_ready),  32'd1);
      chk("fl.sys_evt",   32'(sys_evt),   32'd0);
      @(negedge clk);
      chk("fl.sys_evt2",  32'(sys_evt),   32'd0);
      chk("fl.still_idle", 32'(out_valid), 32'd0);
      push(32'h3000, 32'h0090_0393);
      @(negedge clk);
      chk("fl.post.valid", 32'(out_valid), 32'd1);
      chk("fl.post.pc",    out_pc,         32'h3000);
      chk("fl.post.imm",   out_imm,        32'd9);
      chk("fl.post.rd",    32'(out_rd),    32'd7);
      @(negedge clk);
      chk("fl.post.drained", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
